// File: rtl/dica_ckpt_ctrl.sv
// Checkpoint sequencer for the dirty-block tracker.
// On a request it snapshots the dirty bitmap and stalls the CPU. It copies each
// dirty DMEM block word by word into the NVM shadow region and clears the
// tracker's dirty bit for that block. It finishes with a commit word, which is
// the atomicity point of the checkpoint. A checkpoint cut short by reset never
// writes the commit word.
module dica_ckpt_ctrl #(
    parameter int unsigned  BLK_SIZE       = 16,
    parameter logic [15:0]  DMEM_BASE      = 16'h0200,
    parameter logic [15:0]  DMEM_SIZE      = 16'h0080,
    parameter logic [15:0]  NVM_BASE       = 16'hA000,
    parameter logic [15:0]  NV_COMMIT_ADDR = 16'h9FFE,
    localparam int unsigned NBLK           = 32'(DMEM_SIZE) / BLK_SIZE
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ckpt_start,
    input  logic [NBLK-1:0] d_table,
    output logic            cpu_stall,
    output logic            ckpt_busy,
    output logic            ckpt_done,
    output logic [15:0]     blk_cnt,
    output logic            dm_rd,
    output logic [15:0]     dm_addr,
    input  logic [15:0]     dm_rdata,
    input  logic            dm_ack,
    output logic            nv_wr,
    output logic [15:0]     nv_addr,
    output logic [15:0]     nv_wdata,
    input  logic            nv_ack,
    output logic            dt_clr,
    output logic [15:0]     dt_clr_idx
);

    localparam int unsigned WPB    = BLK_SIZE / 2;
    localparam int unsigned IDX_W  = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int unsigned WORD_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NBLK - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WPB - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_RD     = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_CLR    = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]        state_reg,  state_next;
    logic [NBLK-1:0]   snap_reg,   snap_next;
    logic [IDX_W-1:0]  idx_reg,    idx_next;
    logic [WORD_W-1:0] word_reg,   word_next;
    logic [15:0]       cnt_reg,    cnt_next;
    logic [15:0]       data_reg,   data_next;
    logic [15:0]       blk_cnt_reg, blk_cnt_next;

    // Registered copies of the Moore outputs, computed from the next state
    logic        cpu_stall_reg, busy_next;
    logic        ckpt_done_reg, ckpt_done_next;
    logic        dm_rd_reg,     dm_rd_next;
    logic [15:0] dm_addr_reg,   dm_addr_next;
    logic        nv_wr_reg,     nv_wr_next;
    logic [15:0] nv_addr_reg,   nv_addr_next;
    logic [15:0] nv_wdata_reg,  nv_wdata_next;
    logic        dt_clr_reg,    dt_clr_next;
    logic [15:0] dt_clr_idx_reg, dt_clr_idx_next;
    logic        ckpt_busy_reg;
    logic [15:0] blk_off, word_off;

    // Snapshot bits: loaded on start accept, each bit dropped when its block is cleared
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_snap
        // Per-block snapshot update
        always_comb begin
            snap_next[gi] = snap_reg[gi];
            if (state_reg == S_IDLE && ckpt_start) begin
                snap_next[gi] = d_table[gi];
            end else if (state_reg == S_CLR && idx_reg == IDX_W'(gi)) begin
                snap_next[gi] = 1'b0;
            end
        end
    end

    // Sequencer next-state logic: scan, copy word pairs, clear, commit
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        word_next    = word_reg;
        cnt_next     = cnt_reg;
        data_next    = data_reg;
        blk_cnt_next = blk_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (ckpt_start) begin
                    idx_next   = '0;
                    cnt_next   = '0;
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (snap_reg[idx_reg]) begin
                    word_next  = '0;
                    state_next = S_RD;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = S_COMMIT;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            S_RD: begin
                if (dm_ack) begin
                    data_next  = dm_rdata;
                    state_next = S_WR;
                end
            end
            S_WR: begin
                if (nv_ack) begin
                    if (word_reg == LAST_WORD) begin
                        state_next = S_CLR;
                    end else begin
                        word_next  = word_reg + 1'b1;
                        state_next = S_RD;
                    end
                end
            end
            S_CLR: begin
                cnt_next = cnt_reg + 16'd1;
                if (idx_reg == LAST_IDX) begin
                    state_next = S_COMMIT;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = S_SCAN;
                end
            end
            S_COMMIT: begin
                if (nv_ack) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                blk_cnt_next = cnt_reg;
                state_next   = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so the registered outputs track the state exactly
    always_comb begin
        blk_off  = 16'(32'(idx_next) * BLK_SIZE);
        word_off = 16'({word_next, 1'b0});

        busy_next       = (state_next != S_IDLE);
        ckpt_done_next  = (state_next == S_DONE);
        dm_rd_next      = (state_next == S_RD);
        dm_addr_next    = 16'h0000;
        nv_wr_next      = (state_next == S_WR) || (state_next == S_COMMIT);
        nv_addr_next    = 16'h0000;
        nv_wdata_next   = 16'h0000;
        dt_clr_next     = (state_next == S_CLR);
        dt_clr_idx_next = 16'h0000;

        if (state_next == S_RD) begin
            dm_addr_next = DMEM_BASE + blk_off + word_off;
        end
        if (state_next == S_WR) begin
            nv_addr_next  = NVM_BASE + blk_off + word_off;
            nv_wdata_next = data_next;
        end else if (state_next == S_COMMIT) begin
            nv_addr_next  = NV_COMMIT_ADDR;
            nv_wdata_next = cnt_next;
        end
        if (state_next == S_CLR) begin
            dt_clr_idx_next = 16'(idx_next);
        end
    end

    // State, datapath and output registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_reg      <= S_IDLE;
            snap_reg       <= '0;
            idx_reg        <= '0;
            word_reg       <= '0;
            cnt_reg        <= '0;
            data_reg       <= '0;
            blk_cnt_reg    <= '0;
            cpu_stall_reg  <= 1'b0;
            ckpt_busy_reg  <= 1'b0;
            ckpt_done_reg  <= 1'b0;
            dm_rd_reg      <= 1'b0;
            dm_addr_reg    <= '0;
            nv_wr_reg      <= 1'b0;
            nv_addr_reg    <= '0;
            nv_wdata_reg   <= '0;
            dt_clr_reg     <= 1'b0;
            dt_clr_idx_reg <= '0;
        end else begin
            state_reg      <= state_next;
            snap_reg       <= snap_next;
            idx_reg        <= idx_next;
            word_reg       <= word_next;
            cnt_reg        <= cnt_next;
            data_reg       <= data_next;
            blk_cnt_reg    <= blk_cnt_next;
            cpu_stall_reg  <= busy_next;
            ckpt_busy_reg  <= busy_next;
            ckpt_done_reg  <= ckpt_done_next;
            dm_rd_reg      <= dm_rd_next;
            dm_addr_reg    <= dm_addr_next;
            nv_wr_reg      <= nv_wr_next;
            nv_addr_reg    <= nv_addr_next;
            nv_wdata_reg   <= nv_wdata_next;
            dt_clr_reg     <= dt_clr_next;
            dt_clr_idx_reg <= dt_clr_idx_next;
        end
    end

    assign cpu_stall  = cpu_stall_reg;
    assign ckpt_busy  = ckpt_busy_reg;
    assign ckpt_done  = ckpt_done_reg;
    assign blk_cnt    = blk_cnt_reg;
    assign dm_rd      = dm_rd_reg;
    assign dm_addr    = dm_addr_reg;
    assign nv_wr      = nv_wr_reg;
    assign nv_addr    = nv_addr_reg;
    assign nv_wdata   = nv_wdata_reg;
    assign dt_clr     = dt_clr_reg;
    assign dt_clr_idx = dt_clr_idx_reg;

endmodule

// File: tb/tb_dica_ckpt_ctrl.sv
// Self-checking bench for dica_ckpt_ctrl: directed scenarios plus randomized
// bitmaps, data and ack timing, checked against a transaction-level model.
module tb_dica_ckpt_ctrl;

    localparam int          BLK_SIZE  = 16;
    localparam int          NBLK      = 8;
    localparam int          WPB       = BLK_SIZE / 2;
    localparam logic [15:0] DMEM_BASE = 16'h0200;
    localparam logic [15:0] NVM_BASE  = 16'hA000;
    localparam logic [15:0] COMMIT_A  = 16'h9FFE;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        ckpt_start = 1'b0;
    logic [7:0]  d_table = 8'h00;
    logic        cpu_stall, ckpt_busy, ckpt_done;
    logic [15:0] blk_cnt;
    logic        dm_rd;
    logic [15:0] dm_addr;
    logic [15:0] dm_rdata = 16'h0000;
    logic        dm_ack = 1'b0;
    logic        nv_wr;
    logic [15:0] nv_addr, nv_wdata;
    logic        nv_ack = 1'b0;
    logic        dt_clr;
    logic [15:0] dt_clr_idx;

    dica_ckpt_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ckpt_start (ckpt_start),
        .d_table    (d_table),
        .cpu_stall  (cpu_stall),
        .ckpt_busy  (ckpt_busy),
        .ckpt_done  (ckpt_done),
        .blk_cnt    (blk_cnt),
        .dm_rd      (dm_rd),
        .dm_addr    (dm_addr),
        .dm_rdata   (dm_rdata),
        .dm_ack     (dm_ack),
        .nv_wr      (nv_wr),
        .nv_addr    (nv_addr),
        .nv_wdata   (nv_wdata),
        .nv_ack     (nv_ack),
        .dt_clr     (dt_clr),
        .dt_clr_idx (dt_clr_idx)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    int ack_mode = 0;      // 0: acks tied high, 1: random acks
    int dm_hold = 0;       // forced-low dm_ack cycles while dm_rd is high
    logic [15:0] dmem [0:63];

    logic [15:0] rd_q [$];
    logic [31:0] wr_q [$];
    logic [15:0] clr_q [$];
    int          done_q [$];

    logic        prev_dm_wait = 1'b0, prev_nv_wait = 1'b0;
    logic [15:0] prev_dm_addr = 16'h0, prev_nv_addr = 16'h0, prev_nv_wdata = 16'h0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [15:0] dmem_word(input logic [15:0] a);
        logic [15:0] off;
        off = a - DMEM_BASE;
        if (off < 16'd128) return dmem[off[6:1]];
        return 16'hBAD0;
    endfunction

    // Memory responder and bus monitor, active on the falling edge
    always @(negedge clk) begin
        if (prev_dm_wait) begin
            vectors++;
            if (dm_rd !== 1'b1 || dm_addr !== prev_dm_addr) begin
                miscompares++;
                $display("FAIL dm_hold: dm_rd=%b addr=%h, required 1 addr=%h", dm_rd, dm_addr, prev_dm_addr);
            end
        end
        if (prev_nv_wait) begin
            vectors++;
            if (nv_wr !== 1'b1 || nv_addr !== prev_nv_addr || nv_wdata !== prev_nv_wdata) begin
                miscompares++;
                $display("FAIL nv_hold: nv_wr=%b addr=%h data=%h, required 1 %h %h",
                         nv_wr, nv_addr, nv_wdata, prev_nv_addr, prev_nv_wdata);
            end
        end
        vectors++;
        if (cpu_stall !== ckpt_busy) begin
            miscompares++;
            $display("FAIL stall_vs_busy: cpu_stall=%b, required %b", cpu_stall, ckpt_busy);
        end

        if (ack_mode == 0) begin
            dm_ack = 1'b1;
            nv_ack = 1'b1;
        end else begin
            dm_ack = ($urandom_range(0, 2) != 0);
            nv_ack = ($urandom_range(0, 2) != 0);
        end
        if (dm_rd && dm_hold > 0) begin
            dm_ack = 1'b0;
            dm_hold--;
        end
        dm_rdata = dm_ack ? dmem_word(dm_addr) : 16'($urandom);

        if (dm_rd && dm_ack) rd_q.push_back(dm_addr);
        if (nv_wr && nv_ack) wr_q.push_back({nv_addr, nv_wdata});
        if (dt_clr) clr_q.push_back(dt_clr_idx);
        if (ckpt_done) done_q.push_back(cyc - start_cyc);

        prev_dm_wait  = dm_rd && !dm_ack;
        prev_dm_addr  = dm_addr;
        prev_nv_wait  = nv_wr && !nv_ack;
        prev_nv_addr  = nv_addr;
        prev_nv_wdata = nv_wdata;
    end

    task automatic fill_dmem();
        for (int i = 0; i < 64; i++) dmem[i] = 16'($urandom);
    endtask

    task automatic start_ckpt(input logic [7:0] dt);
        @(negedge clk);
        rd_q.delete();
        wr_q.delete();
        clr_q.delete();
        done_q.delete();
        d_table    = dt;
        ckpt_start = 1'b1;
        start_cyc  = cyc;
        @(negedge clk);
        ckpt_start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        int n;
        n = 0;
        while (done_q.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (done_q.size() == 0) begin
            miscompares++;
            $display("FAIL done_timeout: no ckpt_done within %0d cycles", n);
        end else if (exp_cyc >= 0 && done_q[0] != exp_cyc) begin
            miscompares++;
            $display("FAIL done_cycle: got %0d, required %0d", done_q[0], exp_cyc);
        end
        repeat (3) @(negedge clk);
    endtask

    // Transaction-level model: reads, copies and clears of every dirty block, then commit
    task automatic check_result(input string name, input logic [7:0] dt);
        logic [15:0] er [$];
        logic [31:0] ew [$];
        logic [15:0] ec [$];
        logic [15:0] da, na;
        int pop;
        pop = 0;
        for (int k = 0; k < NBLK; k++) begin
            if (dt[k]) begin
                pop++;
                ec.push_back(16'(k));
                for (int w = 0; w < WPB; w++) begin
                    da = DMEM_BASE + 16'(k * BLK_SIZE + 2 * w);
                    na = NVM_BASE + 16'(k * BLK_SIZE + 2 * w);
                    er.push_back(da);
                    ew.push_back({na, dmem_word(da)});
                end
            end
        end
        ew.push_back({COMMIT_A, 16'(pop)});

        vectors++;
        if (rd_q.size() != er.size()) begin
            miscompares++;
            $display("FAIL %s rd_count: got %0d, required %0d", name, rd_q.size(), er.size());
        end
        for (int i = 0; i < er.size() && i < rd_q.size(); i++) begin
            vectors++;
            if (rd_q[i] !== er[i]) begin
                miscompares++;
                $display("FAIL %s rd[%0d]: got %h, required %h", name, i, rd_q[i], er[i]);
            end
        end
        vectors++;
        if (wr_q.size() != ew.size()) begin
            miscompares++;
            $display("FAIL %s wr_count: got %0d, required %0d", name, wr_q.size(), ew.size());
        end
        for (int i = 0; i < ew.size() && i < wr_q.size(); i++) begin
            vectors++;
            if (wr_q[i] !== ew[i]) begin
                miscompares++;
                $display("FAIL %s wr[%0d]: got %h, required %h", name, i, wr_q[i], ew[i]);
            end
        end
        vectors++;
        if (clr_q.size() != ec.size()) begin
            miscompares++;
            $display("FAIL %s clr_count: got %0d, required %0d", name, clr_q.size(), ec.size());
        end
        for (int i = 0; i < ec.size() && i < clr_q.size(); i++) begin
            vectors++;
            if (clr_q[i] !== ec[i]) begin
                miscompares++;
                $display("FAIL %s clr[%0d]: got %0d, required %0d", name, i, clr_q[i], ec[i]);
            end
        end
        vectors++;
        if (done_q.size() != 1) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d, required 1", name, done_q.size());
        end
        vectors++;
        if (blk_cnt !== 16'(pop)) begin
            miscompares++;
            $display("FAIL %s blk_cnt: got %0d, required %0d", name, blk_cnt, pop);
        end
        vectors++;
        if (ckpt_busy !== 1'b0 || cpu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_after: busy=%b stall=%b, required 0 0", name, ckpt_busy, cpu_stall);
        end
        $display("%s: d_table=%h reads=%0d writes=%0d clears=%0d blk_cnt=%0d",
                 name, dt, rd_q.size(), wr_q.size(), clr_q.size(), blk_cnt);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({cpu_stall, ckpt_busy, ckpt_done, blk_cnt, dm_rd, dm_addr, nv_wr, nv_addr,
             nv_wdata, dt_clr, dt_clr_idx} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b stall=%b dm_rd=%b nv_wr=%b dt_clr=%b blk_cnt=%0d, required all 0",
                     ckpt_busy, cpu_stall, dm_rd, nv_wr, dt_clr, blk_cnt);
        end
        reset_n = 1'b0;
        $display("reset: outputs sampled after 2 reset cycles");
    endtask

    task automatic test_clean(input string name, input logic [7:0] dt);
        int pop;
        pop = $countones(dt);
        ack_mode = 0;
        fill_dmem();
        start_ckpt(dt);
        wait_done(NBLK + 2 + pop * (2 * WPB + 1));
        check_result(name, dt);
    endtask

    task automatic test_dm_stall();
        int n;
        ack_mode = 0;
        fill_dmem();
        dm_hold = 3;
        start_ckpt(8'h01);
        n = 0;
        while (dm_rd !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dm_rd !== 1'b1 || dm_addr !== 16'h0200 || nv_wr !== 1'b0) begin
                miscompares++;
                $display("FAIL dm_stall cycle%0d: dm_rd=%b addr=%h nv_wr=%b, required 1 0200 0",
                         i, dm_rd, dm_addr, nv_wr);
            end
            @(negedge clk);
        end
        vectors++;
        if (nv_wr !== 1'b1 || nv_addr !== 16'hA000) begin
            miscompares++;
            $display("FAIL dm_stall first_wr: nv_wr=%b addr=%h, required 1 A000", nv_wr, nv_addr);
        end
        wait_done(NBLK + 2 + (2 * WPB + 1) + 3);
        check_result("dm_stall", 8'h01);
    endtask

    task automatic test_reset_mid();
        int n;
        logic [15:0] wa;
        ack_mode = 0;
        fill_dmem();
        start_ckpt(8'h04);
        n = 0;
        // third copy write of block 2 sits at A024
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(nv_wr === 1'b1 && nv_addr === 16'hA024) && n < 100);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (ckpt_busy !== 1'b0 || cpu_stall !== 1'b0 || nv_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid idle: busy=%b stall=%b nv_wr=%b, required 0 0 0", ckpt_busy, cpu_stall, nv_wr);
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < wr_q.size(); i++) begin
            wa = wr_q[i][31:16];
            vectors++;
            if (wa === COMMIT_A) begin
                miscompares++;
                $display("FAIL reset_mid commit: write %0d to %h, required no commit write", i, wa);
            end
        end
        vectors++;
        if (wr_q.size() != 3 || done_q.size() != 0 || clr_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid traffic: writes=%0d done=%0d clr=%0d, required 3 0 0",
                     wr_q.size(), done_q.size(), clr_q.size());
        end
        vectors++;
        if (blk_cnt !== 16'd0 || cpu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid state: blk_cnt=%0d stall=%b, required 0 0", blk_cnt, cpu_stall);
        end
        $display("reset_mid: writes=%0d blk_cnt=%0d", wr_q.size(), blk_cnt);
    endtask

    task automatic test_snapshot_isolation();
        ack_mode = 0;
        fill_dmem();
        start_ckpt(8'h02);
        repeat (3) @(negedge clk);
        d_table    = 8'hFF;
        ckpt_start = 1'b1;
        repeat (10) @(negedge clk);
        ckpt_start = 1'b0;
        wait_done(NBLK + 2 + (2 * WPB + 1));
        repeat (20) @(negedge clk);
        check_result("snapshot", 8'h02);
        d_table = 8'h00;
    endtask

    task automatic test_random();
        logic [7:0] dt;
        for (int t = 0; t < 8; t++) begin
            dt = 8'($urandom);
            fill_dmem();
            ack_mode = (t < 2) ? 0 : 1;
            start_ckpt(dt);
            wait_done(ack_mode == 0 ? NBLK + 2 + $countones(dt) * (2 * WPB + 1) : -1);
            ack_mode = 0;
            repeat (2) @(negedge clk);
            check_result("random", dt);
        end
    endtask

    task automatic test_back_to_back();
        ack_mode = 1;
        fill_dmem();
        start_ckpt(8'h81);
        wait_done(-1);
        check_result("b2b_a", 8'h81);
        start_ckpt(8'h18);
        wait_done(-1);
        ack_mode = 0;
        check_result("b2b_b", 8'h18);
    endtask

    initial begin
        test_reset();
        test_clean("dirty_05", 8'h05);
        test_dm_stall();
        test_clean("clean_00", 8'h00);
        test_reset_mid();
        test_snapshot_isolation();
        test_clean("all_dirty", 8'hFF);
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
